// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the multi-cycle ALU issue controller.
//                Holds the ALU operation codes, the decode-stage alu_op
//                encodings, the controller FSM state type, the internal
//                operation class and the request decode function.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

  // Operation codes understood by the combinational ALU
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_EQ  = 4'b1000;
  localparam logic [3:0] ALU_XOR = 4'b1001;

  // alu_op encodings produced by the main decoder
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU      = 3'd0,
    CLS_SLT      = 3'd1,
    CLS_SLTU     = 3'd2,
    CLS_SHIFT_L  = 3'd3,
    CLS_SHIFT_RL = 3'd4,
    CLS_SHIFT_RA = 3'd5,
    CLS_ILLEGAL  = 3'd6
  } op_class_t;

  // is_bool: result is the 0/1 EQ flag rather than the raw ALU result.
  // invert : the 0/1 result is complemented (BNE/BGE/BGEU).
  typedef struct packed {
    op_class_t  cls;
    logic [3:0] alu_code;
    logic       invert;
    logic       is_bool;
  } dec_t;

  function automatic dec_t decode_op(input logic [1:0] alu_op,
                                     input logic [2:0] funct3,
                                     input logic       funct7_5);
    dec_t d;
    d.cls      = CLS_ALU;
    d.alu_code = ALU_ADD;
    d.invert   = 1'b0;
    d.is_bool  = 1'b0;
    case (alu_op)
      ALUOP_BRANCH: begin
        case (funct3)
          3'b000: begin d.alu_code = ALU_EQ; d.is_bool = 1'b1; end
          3'b001: begin d.alu_code = ALU_EQ; d.is_bool = 1'b1; d.invert = 1'b1; end
          3'b100: begin d.cls = CLS_SLT;  d.alu_code = ALU_SUB; end
          3'b101: begin d.cls = CLS_SLT;  d.alu_code = ALU_SUB; d.invert = 1'b1; end
          3'b110: begin d.cls = CLS_SLTU; d.alu_code = ALU_SUB; end
          3'b111: begin d.cls = CLS_SLTU; d.alu_code = ALU_SUB; d.invert = 1'b1; end
          default: d.cls = CLS_ILLEGAL;  // ALU still driven with ADD
        endcase
      end
      ALUOP_RTYPE, ALUOP_ITYPE: begin
        case (funct3)
          // funct7_5 selects SUB only for register-register ops; for
          // immediates bit 30 is part of the immediate value.
          3'b000: d.alu_code = (alu_op == ALUOP_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001: d.cls = CLS_SHIFT_L;
          3'b010: begin d.cls = CLS_SLT;  d.alu_code = ALU_SUB; end
          3'b011: begin d.cls = CLS_SLTU; d.alu_code = ALU_SUB; end
          3'b100: d.alu_code = ALU_XOR;
          3'b101: d.cls = funct7_5 ? CLS_SHIFT_RA : CLS_SHIFT_RL;
          3'b110: d.alu_code = ALU_OR;
          default: d.alu_code = ALU_AND;
        endcase
      end
      default: d.alu_code = ALU_ADD;  // load/store address generation
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_serial_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_serial_shifter
//  Description : One-bit-per-cycle shifter. On load the accumulator takes
//                src and the counter takes shamt; each step cycle with a
//                non-zero counter shifts by one and decrements. done is high
//                whenever the counter is zero.
//  Ports       : clk, rst_n       - clock, async active-low reset
//                load             - capture src/shamt/direction controls
//                step             - advance one bit position
//                src, shamt       - initial accumulator and shift count
//                shift_left       - 1: SLL, 0: right shift
//                shift_arith      - right shifts replicate the MSB
//                acc, done        - accumulator value, counter-empty flag
//  Revision    : 1.0  initial release
// ============================================================================
module alu_serial_shifter #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   step,
  input  logic [DATA_WIDTH-1:0]  src,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  input  logic                   shift_left,
  input  logic                   shift_arith,
  output logic [DATA_WIDTH-1:0]  acc,
  output logic                   done
);

  logic [SHAMT_WIDTH-1:0] cnt;
  logic                   left_q;
  logic                   arith_q;
  logic                   fill_bit;

  assign done     = (cnt == '0);
  assign fill_bit = arith_q & acc[DATA_WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (load) begin
      acc     <= src;
      cnt     <= shamt;
      left_q  <= shift_left;
      arith_q <= shift_arith;
    end else if (step && !done) begin
      cnt <= cnt - 1'b1;
      if (left_q)
        acc <= {acc[DATA_WIDTH-2:0], 1'b0};
      else
        acc <= {fill_bit, acc[DATA_WIDTH-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_ctrl
//  Description : Multi-cycle ALU issue controller. Accepts a decoded request
//                over valid/ready, drives the external combinational ALU for
//                one cycle (or runs the serial shifter), post-processes
//                compares and returns a registered result over valid/ready.
//  Ports       : clk, rst_n                  - clock, async active-low reset
//                in_valid/in_ready           - request handshake
//                alu_op, funct3, funct7_5    - decoded instruction fields
//                src_a, src_b                - operands
//                alu_srca/alu_srcb/alu_operation - to ALU (held outside EXEC)
//                alu_result                  - from ALU
//                out_valid/out_ready         - result handshake
//                result, illegal             - registered response
//  Revision    : 1.0  initial release
// ============================================================================
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int SHAMT_WIDTH   = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               alu_op,
  input  logic [2:0]               funct3,
  input  logic                     funct7_5,
  input  logic [DATA_WIDTH-1:0]    src_a,
  input  logic [DATA_WIDTH-1:0]    src_b,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_operation,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    result,
  output logic                     illegal
);

  state_t    state;
  state_t    state_next;
  dec_t      dec_in;
  op_class_t cls_q;
  logic      invert_q;
  logic      is_bool_q;

  logic accept;
  logic is_shift_in;
  logic exec_capture;
  logic shift_step;
  logic shift_capture;
  logic shift_done;

  logic [DATA_WIDTH-1:0] shift_acc;
  logic [DATA_WIDTH-1:0] exec_value;
  logic sign_diff;
  logic slt_bit;
  logic sltu_bit;
  logic eq_bit;

  assign dec_in      = decode_op(alu_op, funct3, funct7_5);
  assign accept      = in_valid && in_ready;
  assign is_shift_in = (dec_in.cls == CLS_SHIFT_L)  ||
                       (dec_in.cls == CLS_SHIFT_RL) ||
                       (dec_in.cls == CLS_SHIFT_RA);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next    = state;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    exec_capture  = 1'b0;
    shift_step    = 1'b0;
    shift_capture = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_next = is_shift_in ? ST_SHIFT : ST_EXEC;
      end
      ST_EXEC: begin
        exec_capture = 1'b1;
        state_next   = ST_DONE;
      end
      ST_SHIFT: begin
        if (shift_done) begin
          shift_capture = 1'b1;
          state_next    = ST_DONE;
        end else begin
          shift_step = 1'b1;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Compare post-processing on the ALU result. The registered ALU operands
  // are the compare operands; on a sign mismatch the SUB result may have
  // overflowed, so the answer comes straight from the operand sign bits.
  // --------------------------------------------------------------------------
  assign sign_diff = alu_srca[DATA_WIDTH-1] ^ alu_srcb[DATA_WIDTH-1];
  assign slt_bit   = sign_diff ? alu_srca[DATA_WIDTH-1] : alu_result[DATA_WIDTH-1];
  assign sltu_bit  = sign_diff ? alu_srcb[DATA_WIDTH-1] : alu_result[DATA_WIDTH-1];
  assign eq_bit    = |alu_result;

  always_comb begin
    exec_value = '0;
    case (cls_q)
      CLS_ALU: begin
        if (is_bool_q)
          exec_value = {{(DATA_WIDTH-1){1'b0}}, eq_bit ^ invert_q};
        else
          exec_value = alu_result;
      end
      CLS_SLT:  exec_value = {{(DATA_WIDTH-1){1'b0}}, slt_bit ^ invert_q};
      CLS_SLTU: exec_value = {{(DATA_WIDTH-1){1'b0}}, sltu_bit ^ invert_q};
      default:  exec_value = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers. The ALU drive registers double as the operand
  // registers: they are loaded on accept of any non-shift op, so they show
  // the issued values during EXEC and hold them afterwards. Shift requests
  // leave them untouched because shifts never use the ALU.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_srca      <= '0;
      alu_srcb      <= '0;
      alu_operation <= OPCODE_LENGTH'(ALU_ADD);
      cls_q         <= CLS_ALU;
      invert_q      <= 1'b0;
      is_bool_q     <= 1'b0;
      result        <= '0;
      illegal       <= 1'b0;
    end else begin
      if (accept) begin
        cls_q     <= dec_in.cls;
        invert_q  <= dec_in.invert;
        is_bool_q <= dec_in.is_bool;
        if (!is_shift_in) begin
          alu_srca      <= src_a;
          alu_srcb      <= src_b;
          alu_operation <= OPCODE_LENGTH'(dec_in.alu_code);
        end
      end
      if (exec_capture) begin
        result  <= exec_value;
        illegal <= (cls_q == CLS_ILLEGAL);
      end
      if (shift_capture) begin
        result  <= shift_acc;
        illegal <= 1'b0;
      end
    end
  end

  alu_serial_shifter #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH)
  ) u_shifter (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (accept && is_shift_in),
    .step        (shift_step),
    .src         (src_a),
    .shamt       (src_b[SHAMT_WIDTH-1:0]),
    .shift_left  (dec_in.cls == CLS_SHIFT_L),
    .shift_arith (dec_in.cls == CLS_SHIFT_RA),
    .acc         (shift_acc),
    .done        (shift_done)
  );

endmodule
`default_nettype wire
